// File: rtl/dial_pkg.sv
// dial_pkg
// Shared types for the dial emulator: direction enum, step width and the
// angle width, plus a small unsigned-minimum helper used by the ramp logic.
// Optional feature macro used elsewhere in this slice: DIAL_MOUSE_EN.
`timescale 1ns/1ps

package dial_pkg;

  localparam int ANGLE_W = 8;

  // Four bits cover every step up to 15, which includes the high-range maximum.
  typedef logic [3:0] step_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW
  } dir_t;

  function automatic step_t stepMin(input step_t a, input step_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dial_step_ramp.sv
// dial_step_ramp
// Hold-time acceleration ramp. On every frame tick it produces the unsigned
// step magnitude to apply and advances its own step / ramp counter / last
// direction state. Between ticks the delta output is zero.
//
// Ports:
//   clk_sys  in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   i_tick   in   one-cycle frame tick
//   i_dir    in   direction sampled at the tick
//   i_max    in   current maximum step (depends on speed select)
//   o_delta  out  step magnitude to apply this cycle (0 when no tick)
`timescale 1ns/1ps

module dial_step_ramp
  import dial_pkg::*;
#(
  parameter int RAMP_FRAMES = 4
) (
  input  logic  clk_sys,
  input  logic  reset,
  input  logic  i_tick,
  input  dir_t  i_dir,
  input  step_t i_max,
  output step_t o_delta
);

  localparam logic [15:0] RAMP_LAST = 16'(RAMP_FRAMES - 1);

  step_t       r_step;
  logic [15:0] r_rampCnt;
  dir_t        r_lastDir;

  step_t       w_stepNext;
  logic [15:0] w_rampNext;
  dir_t        w_lastDirNext;
  step_t       w_stepClamped;
  step_t       w_stepInc;

  // State register; reset restarts the ramp so the next tick moves by one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_step    <= step_t'(1);
      r_rampCnt <= '0;
      r_lastDir <= DIR_NONE;
    end else begin
      r_step    <= w_stepNext;
      r_rampCnt <= w_rampNext;
      r_lastDir <= w_lastDirNext;
    end
  end

  // Next-state and delta. The increment saturates at the current maximum
  // before adding so a 4-bit step can never wrap past 15. Holding the same
  // direction also re-clamps the stored step, which covers the speed select
  // dropping from high to low range mid-spin.
  always_comb begin
    w_stepNext    = r_step;
    w_rampNext    = r_rampCnt;
    w_lastDirNext = r_lastDir;
    o_delta       = '0;
    w_stepClamped = stepMin(r_step, i_max);
    w_stepInc     = (r_step >= i_max) ? i_max : step_t'(r_step + step_t'(1));

    if (i_tick) begin
      if (i_dir == DIR_NONE) begin
        w_stepNext    = step_t'(1);
        w_rampNext    = '0;
        w_lastDirNext = DIR_NONE;
      end else if (i_dir != r_lastDir) begin
        o_delta       = step_t'(1);
        w_lastDirNext = i_dir;
        if (RAMP_FRAMES == 1) begin
          w_stepNext = stepMin(step_t'(2), i_max);
          w_rampNext = '0;
        end else begin
          w_stepNext = step_t'(1);
          w_rampNext = 16'd1;
        end
      end else begin
        o_delta = w_stepClamped;
        if (r_rampCnt == RAMP_LAST) begin
          w_rampNext = '0;
          w_stepNext = w_stepInc;
        end else begin
          w_rampNext = r_rampCnt + 16'd1;
          w_stepNext = w_stepClamped;
        end
      end
    end
  end

endmodule

// File: rtl/dial_emulator.sv
// dial_emulator
// Emulates the MCR-scroll rotary spinner from digital left/right buttons.
// Once per video frame (rising edge of vsync) the angle moves by a step that
// ramps up while a direction is held. The angle wraps modulo 256.
//
// Ports:
//   clk_sys     in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   btn_left    in   counter-clockwise request (level)
//   btn_right   in   clockwise request (level)
//   btn_acc     in   speed select: 0 low range, 1 high range
//   vsync       in   frame pulse, any width, synchronous to clk_sys
//   spin_angle  out  accumulated dial angle, modulo 256
//   moving      out  last frame tick applied a non-zero step
//   mouse_strobe in  (DIAL_MOUSE_EN only) mouse delta valid
//   mouse_dx    in   (DIAL_MOUSE_EN only) signed 9-bit mouse delta
//
// Optional feature macro: DIAL_MOUSE_EN adds a mouse path that is scaled by
// MOUSE_SHIFT and summed into the angle alongside any frame step.
`timescale 1ns/1ps

module dial_emulator
  import dial_pkg::*;
#(
  parameter int STEP_LOW_MAX  = 4,
  parameter int STEP_HIGH_MAX = 12,
`ifdef DIAL_MOUSE_EN
  parameter int RAMP_FRAMES   = 4,
  parameter int MOUSE_SHIFT   = 2
`else
  parameter int RAMP_FRAMES   = 4
`endif
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_acc,
  input  logic               vsync,
`ifdef DIAL_MOUSE_EN
  input  logic               mouse_strobe,
  input  logic signed [8:0]  mouse_dx,
`endif
  output logic [ANGLE_W-1:0] spin_angle,
  output logic               moving
);

  logic               r_vsPrev;
  logic [ANGLE_W-1:0] r_angle;
  logic               r_moving;

  logic               w_tick;
  dir_t               w_dir;
  step_t              w_max;
  step_t              w_delta;
  logic [ANGLE_W-1:0] w_frameDelta;
  logic [ANGLE_W-1:0] w_mouseDelta;
  logic [ANGLE_W-1:0] w_angleNext;

  // Rising edge of vsync. The previous-value register resets high so a vsync
  // already high when reset releases does not count as a new frame.
  assign w_tick = vsync & ~r_vsPrev;

  // Both or neither button pressed means no direction.
  always_comb begin
    w_dir = DIR_NONE;
    if (btn_right & ~btn_left) begin
      w_dir = DIR_CW;
    end else if (btn_left & ~btn_right) begin
      w_dir = DIR_CCW;
    end
  end

  assign w_max = btn_acc ? step_t'(STEP_HIGH_MAX) : step_t'(STEP_LOW_MAX);

  dial_step_ramp #(
    .RAMP_FRAMES(RAMP_FRAMES)
  ) u_ramp (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_tick  (w_tick),
    .i_dir   (w_dir),
    .i_max   (w_max),
    .o_delta (w_delta)
  );

`ifdef DIAL_MOUSE_EN
  logic signed [8:0] w_mouseShifted;

  // Arithmetic shift keeps the sign; the result is truncated to angle width.
  assign w_mouseShifted = mouse_dx >>> MOUSE_SHIFT;
  assign w_mouseDelta   = mouse_strobe ? w_mouseShifted[ANGLE_W-1:0] : '0;
`else
  assign w_mouseDelta   = '0;
`endif

  // The ramp only outputs a non-zero delta on a tick, so the frame and mouse
  // contributions can simply be summed every cycle; subtraction is done in
  // two's complement so the angle wraps naturally.
  always_comb begin
    w_frameDelta = '0;
    if (w_dir == DIR_CW) begin
      w_frameDelta = {4'b0000, w_delta};
    end else if (w_dir == DIR_CCW) begin
      w_frameDelta = 8'h00 - {4'b0000, w_delta};
    end
    w_angleNext = r_angle + w_frameDelta + w_mouseDelta;
  end

  // Angle accumulator, moving flag and vsync history; reset has priority over
  // a coincident tick.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_vsPrev <= 1'b1;
      r_angle  <= '0;
      r_moving <= 1'b0;
    end else begin
      r_vsPrev <= vsync;
      r_angle  <= w_angleNext;
      if (w_tick) begin
        r_moving <= (w_dir != DIR_NONE);
      end
    end
  end

  assign spin_angle = r_angle;
  assign moving     = r_moving;

endmodule

// File: tb/tb_dial_emulator.sv
// tb_dial_emulator
// Directed bench for the dial emulator: acceleration ramp, wrap-around,
// conflicting buttons, reversal in the high range, long vsync, vsync held
// through reset, and reset mid-ramp. The mouse path is exercised only when
// DIAL_MOUSE_EN is defined.
`timescale 1ns/1ps

module tb_dial_emulator;

  logic       clk_sys;
  logic       reset;
  logic       btn_left;
  logic       btn_right;
  logic       btn_acc;
  logic       vsync;
  logic [7:0] spin_angle;
  logic       moving;
`ifdef DIAL_MOUSE_EN
  logic              mouse_strobe;
  logic signed [8:0] mouse_dx;
`endif

  int checkCount;
  int passCount;

  dial_emulator dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_acc      (btn_acc),
    .vsync        (vsync),
`ifdef DIAL_MOUSE_EN
    .mouse_strobe (mouse_strobe),
    .mouse_dx     (mouse_dx),
`endif
    .spin_angle   (spin_angle),
    .moving       (moving)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Set the buttons at a falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic left, input logic right, input logic acc);
    @(negedge clk_sys);
    btn_left  = left;
    btn_right = right;
    btn_acc   = acc;
  endtask

  // One-cycle synchronous reset with vsync low.
  task automatic doReset();
    @(negedge clk_sys);
    reset = 1'b1;
    vsync = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  // One short vsync pulse; outputs are settled when this returns.
  task automatic frameTick();
    @(negedge clk_sys);
    vsync = 1'b1;
    @(negedge clk_sys);
    vsync = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      frameTick();
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_acc    = 1'b0;
    vsync      = 1'b0;
`ifdef DIAL_MOUSE_EN
    mouse_strobe = 1'b0;
    mouse_dx     = '0;
`endif
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // Reset state.
    checkOutput("reset_angle", spin_angle, 8'd0);
    checkOutput("reset_moving", {7'd0, moving}, 8'd1 - 8'd1);

    // Acceleration ramp in the low range: steps 1,2,3,4 each held 4 frames.
    applyStimulus(1'b0, 1'b1, 1'b0);
    frameTick();
    checkOutput("accel_tick1", spin_angle, 8'd1);
    checkOutput("accel_moving", {7'd0, moving}, 8'd1);
    runTicks(3);
    checkOutput("accel_tick4", spin_angle, 8'd4);
    runTicks(4);
    checkOutput("accel_tick8", spin_angle, 8'd12);
    runTicks(4);
    checkOutput("accel_tick12", spin_angle, 8'd24);
    runTicks(4);
    checkOutput("accel_tick16", spin_angle, 8'd40);
    frameTick();
    checkOutput("accel_tick17", spin_angle, 8'd44);

    // No change between ticks.
    repeat (20) @(negedge clk_sys);
    checkOutput("accel_idle", spin_angle, 8'd44);

    // Wrap below zero.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    frameTick();
    checkOutput("wrap_ff", spin_angle, 8'hFF);
    frameTick();
    checkOutput("wrap_fe", spin_angle, 8'hFE);

    // Both buttons: no movement and the ramp restarts.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    runTicks(8);
    checkOutput("conflict_pre", spin_angle, 8'd12);
    applyStimulus(1'b1, 1'b1, 1'b0);
    frameTick();
    checkOutput("conflict_hold", spin_angle, 8'd12);
    checkOutput("conflict_moving", {7'd0, moving}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    frameTick();
    checkOutput("conflict_restart", spin_angle, 8'd13);
    checkOutput("conflict_moving2", {7'd0, moving}, 8'd1);

    // High range: 40 frames give 4*(1+..+10)=220; reversal steps by 1.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1);
    runTicks(40);
    checkOutput("high_40", spin_angle, 8'd220);
    // 8 more frames: 4*11 + 4*12 = 92, total 312 mod 256 = 56.
    runTicks(8);
    checkOutput("high_48", spin_angle, 8'd56);
    // Saturated at 12: 4 more frames add 48.
    runTicks(4);
    checkOutput("high_sat", spin_angle, 8'd104);
    // Dropping to low range clamps the step to 4 immediately.
    applyStimulus(1'b0, 1'b1, 1'b0);
    frameTick();
    checkOutput("acc_drop_clamp", spin_angle, 8'd108);
    applyStimulus(1'b1, 1'b0, 1'b1);
    frameTick();
    checkOutput("reverse_first", spin_angle, 8'd107);
    frameTick();
    checkOutput("reverse_second", spin_angle, 8'd106);

    // Long vsync gives exactly one update.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk_sys);
    vsync = 1'b1;
    repeat (1000) @(negedge clk_sys);
    checkOutput("long_vsync_high", spin_angle, 8'd1);
    vsync = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("long_vsync_after", spin_angle, 8'd1);

    // Vsync high through reset release: no update until the next real edge.
    @(negedge clk_sys);
    vsync = 1'b1;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    checkOutput("vsync_thru_reset", spin_angle, 8'd0);
    vsync = 1'b0;
    frameTick();
    checkOutput("vsync_after_reset", spin_angle, 8'd1);

    // Reset coincident with a vsync rising edge: reset wins.
    @(negedge clk_sys);
    reset = 1'b1;
    vsync = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    vsync = 1'b0;
    @(negedge clk_sys);
    checkOutput("reset_vs_tick", spin_angle, 8'd0);

    // Reset mid-ramp: 10 frames = 4 + 8 + 6 = 18, then restart at step 1.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    runTicks(10);
    checkOutput("midramp_pre", spin_angle, 8'd18);
    doReset();
    checkOutput("midramp_reset", spin_angle, 8'd0);
    checkOutput("midramp_moving", {7'd0, moving}, 8'd0);
    frameTick();
    checkOutput("midramp_restart", spin_angle, 8'd1);

`ifdef DIAL_MOUSE_EN
    // Mouse delta -8 >>> 2 = -2 summed with a +1 frame step.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk_sys);
    vsync        = 1'b1;
    mouse_strobe = 1'b1;
    mouse_dx     = -9'sd8;
    @(negedge clk_sys);
    vsync        = 1'b0;
    mouse_strobe = 1'b0;
    @(negedge clk_sys);
    checkOutput("mouse_plus_tick", spin_angle, 8'hFF);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
